uart_rx_buf: RTL and testbench

//  Buffered UART receiver, the receive-side counterpart of the buffered transmitter in the UART terminal designs.

---
 rtl/uart_rx_buf_pkg.sv | 24 ++
 rtl/uart_rx_buf_if.sv | 24 ++
 rtl/uart_rx.sv | 116 +++++++++++
 rtl/uart_rx_buf.sv | 102 ++++++++++
 tb/tb_uart_rx_buf.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the UART receive path: receiver FSM state encoding
// and the ceiling-log2 helper used to size counters and buffer pointers.
// No logic, no latency, no backpressure.
package uart_rx_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_buf_if.sv
// Read-side bus of the buffered UART receiver (show-ahead empty/get port plus status flags).
// Pure wiring, no latency.
// Backpressure: the consumer pops with get only when it wants a byte; the buffer never stalls the line.
// master: the buffer (drives data/flags, samples get); slave: the consumer.
interface uart_rx_buf_if;

  logic       get;
  logic [7:0] data;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       frame_err;

  modport master (
    input  get,
    output data, empty, full, overrun, frame_err
  );

  modport slave (
    output get,
    input  data, empty, full, overrun, frame_err
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART deserialiser: 2-flop synchroniser, oversampling FSM and LSB-first shift register.
// Latency: rx_valid_o fires combinationally on the stop-bit sample cycle, 3+HALF_BIT+9*CLKS_PER_BIT clks after RX falls.
// Backpressure: none; the line cannot be stalled, so the consumer must take rx_valid_o when it fires.
// Ports: clk, rst_n (async active-low); rx_i raw pin; rx_data_o byte; rx_valid_o byte done; rx_ferr_o stop bit low.
module uart_rx
  import uart_rx_buf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int HALF_BIT     = 52
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o
);

  localparam int CNT_W = (log2(CLKS_PER_BIT) < 1) ? 1 : log2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  logic             rx_meta_q;
  logic             rxs_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid_o = 1'b0;
    rx_ferr_o  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end

      // Re-check the start bit at its centre so short glitches are rejected.
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // From the start-bit centre, every CLKS_PER_BIT lands on a data-bit centre.
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          rx_valid_o = 1'b1;
          if (rxs_q) begin
            state_d = ST_IDLE;
          end else begin
            rx_ferr_o = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held break must not look like a stream of new start bits.
      ST_WAIT_IDLE: begin
        if (rxs_q) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data_o = shift_q;

endmodule

// File: rtl/uart_rx_buf.sv
// Buffered UART receiver: uart_rx deserialiser feeding an rbuf_size-byte ring buffer with show-ahead read port.
// Latency: a byte is visible (empty=0) the cycle after its stop-bit sample; a get shows the next byte one cycle later.
// Backpressure: none toward the line; a byte arriving into a full buffer (without a same-cycle get) is dropped and sets overrun.
// Ports: clk, rst_n (async active-low), RX serial pin (idle high), bus = uart_rx_buf_if.master
//   (get in; data, empty, full, overrun (sticky), frame_err (1-cycle pulse) out).
// Build option UART_RX_BUF_FRAME_DROP_EN: when defined, bytes whose stop bit was low are not stored.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int clk_freq  = 12000000,
  parameter int baud      = 115200,
  parameter int rbuf_size = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  uart_rx_buf_if.master bus
);

  localparam int CLKS_PER_BIT = clk_freq / baud;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int ADDR_W       = log2(rbuf_size);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (RX),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr)
  );

  // One extra MSB on each pointer distinguishes full from empty.
  logic [ADDR_W:0] wr_q, wr_d;
  logic [ADDR_W:0] rd_q, rd_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q;
  logic [7:0]      rbuf_q [rbuf_size];

  logic store_req;
  logic empty;
  logic full;
  logic do_get;
  logic do_wr;

`ifdef UART_RX_BUF_FRAME_DROP_EN
  assign store_req = rx_valid && !rx_ferr;
`else
  assign store_req = rx_valid;
`endif

  always_comb begin
    empty     = (rd_q == wr_q);
    full      = (rd_q[ADDR_W-1:0] == wr_q[ADDR_W-1:0]) && (rd_q[ADDR_W] != wr_q[ADDR_W]);
    do_get    = bus.get && !empty;
    // A same-cycle pop frees the head slot, so a full buffer can still accept.
    do_wr     = store_req && (!full || do_get);
    wr_d      = wr_q;
    rd_d      = rd_q;
    overrun_d = overrun_q;
    if (do_wr)  wr_d = wr_q + 1'b1;
    if (do_get) rd_d = rd_q + 1'b1;
    if (store_req && full && !do_get) begin
      overrun_d = 1'b1;
    end else if (do_get) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      overrun_q   <= overrun_d;
      frame_err_q <= rx_ferr;
    end
  end

  // Storage needs no reset: reset empties the pointers and data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr) rbuf_q[wr_q[ADDR_W-1:0]] <= rx_data;
  end

  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.data      = empty ? 8'h00 : rbuf_q[rd_q[ADDR_W-1:0]];

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: 16 clks/bit, 4-byte buffer.
// A queue-based model receives each byte at the frame-completion cycle; a negedge process compares every cycle.
module tb_uart_rx_buf;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int DEPTH = 4;
  // RX falls -> 2 sync flops -> idle detect -> half bit -> 8 data bits -> stop bit sample -> stored.
  localparam int LAT   = 3 + HALF + 9 * CPB;
`ifdef UART_RX_BUF_FRAME_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rx;
  uart_rx_buf_if bus ();

  uart_rx_buf #(
    .clk_freq  (16),
    .baud      (1),
    .rbuf_size (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int shown = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int         due;
    logic [7:0] b;
    bit         ferr;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] mq[$];
  bit         m_ovr  = 1'b0;
  bit         m_ferr = 1'b0;
  int         cyc    = 0;

  always @(posedge clk) begin
    int  sz0;
    bit  pop;
    bit  done;
    ev_t e;
    cyc++;
    m_ferr = 1'b0;
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      m_ovr = 1'b0;
    end else begin
      sz0  = mq.size();
      pop  = bus.get && (sz0 > 0);
      done = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e    = pend.pop_front();
        done = 1'b1;
      end
      if (pop) begin
        void'(mq.pop_front());
        m_ovr = 1'b0;
      end
      if (done) begin
        m_ferr = e.ferr;
        if (!e.ferr || !DROP) begin
          if (sz0 == DEPTH && !pop) m_ovr = 1'b1;
          else mq.push_back(e.b);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en  = 1'b0;
  int ferr_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && bus.frame_err) ferr_cnt++;
    if (cmp_en && rst_n) begin
      chk("empty",     {31'd0, bus.empty},     {31'd0, mq.size() == 0});
      chk("full",      {31'd0, bus.full},      {31'd0, mq.size() == DEPTH});
      chk("overrun",   {31'd0, bus.overrun},   {31'd0, m_ovr});
      chk("frame_err", {31'd0, bus.frame_err}, {31'd0, m_ferr});
      if (mq.size() > 0) chk("data", {24'd0, bus.data}, {24'd0, mq[0]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
    ev_t e;
    e.due  = cyc + LAT;
    e.b    = b;
    e.ferr = !stop_ok;
    pend.push_back(e);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_ok;
    cycles(CPB);
    if (extra_low > 0) begin
      rx = 1'b0;
      cycles(extra_low);
    end
    rx = 1'b1;
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_nonempty", {31'd0, bus.empty}, 32'd0);
    chk("pop_head", {24'd0, bus.data}, {24'd0, exp});
    bus.get = 1'b1;
    cycles(1);
    bus.get = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int f0;
    rst_n   = 1'b0;
    rx      = 1'b1;
    bus.get = 1'b0;
    cycles(3);
    chk("rst_empty",   {31'd0, bus.empty},     32'd1);
    chk("rst_full",    {31'd0, bus.full},      32'd0);
    chk("rst_overrun", {31'd0, bus.overrun},   32'd0);
    chk("rst_ferr",    {31'd0, bus.frame_err}, 32'd0);
    chk("rst_data",    {24'd0, bus.data},      32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cycles(5);

    // Single byte: empty falls exactly one cycle after the stop-bit sample.
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        cycles(LAT - 1);
        chk("a5_still_empty", {31'd0, bus.empty}, 32'd1);
        cycles(1);
        chk("a5_now_ready", {31'd0, bus.empty}, 32'd0);
        chk("a5_data", {24'd0, bus.data}, 32'hA5);
      end
    join
    bus.get = 1'b1;
    cycles(1);
    bus.get = 1'b0;
    chk("a5_popped_empty", {31'd0, bus.empty}, 32'd1);

    // Short low glitch is rejected.
    f0 = ferr_cnt;
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    chk("glitch_empty", {31'd0, bus.empty}, 32'd1);
    chk("glitch_no_ferr", ferr_cnt, f0);

    // Fill, overflow, drain.
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'h03, 1'b1, 0);
    send_frame(8'h04, 1'b1, 0);
    cycles(2);
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    chk("fill_no_ovr", {31'd0, bus.overrun}, 32'd0);
    send_frame(8'h55, 1'b1, 0);
    cycles(2);
    chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
    chk("ovr_full", {31'd0, bus.full}, 32'd1);
    pop_chk(8'h01);
    chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
    pop_chk(8'h02);
    pop_chk(8'h03);
    pop_chk(8'h04);
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);

    // Full buffer, pop on the stop-sample cycle of the next byte.
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    send_frame(8'h44, 1'b1, 0);
    cycles(2);
    chk("full2", {31'd0, bus.full}, 32'd1);
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        cycles(LAT - 1);
        chk("same_cyc_head", {24'd0, bus.data}, 32'h11);
        bus.get = 1'b1;
        cycles(1);
        bus.get = 1'b0;
        chk("same_cyc_next", {24'd0, bus.data}, 32'h22);
        chk("same_cyc_full", {31'd0, bus.full}, 32'd1);
        chk("same_cyc_no_ovr", {31'd0, bus.overrun}, 32'd0);
      end
    join
    pop_chk(8'h22);
    pop_chk(8'h33);
    pop_chk(8'h44);
    pop_chk(8'h77);
    chk("drain2_empty", {31'd0, bus.empty}, 32'd1);

    // Bad stop bit followed by a held break.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 40);
    cycles(40);
    chk("ferr_once", ferr_cnt, f0 + 1);
`ifdef UART_RX_BUF_FRAME_DROP_EN
    chk("ferr_dropped", {31'd0, bus.empty}, 32'd1);
`else
    pop_chk(8'h3C);
`endif
    chk("ferr_empty_after", {31'd0, bus.empty}, 32'd1);

    // Six bytes, interleaved pops, pointers wrap.
    send_frame(8'h61, 1'b1, 0);
    send_frame(8'h62, 1'b1, 0);
    send_frame(8'h63, 1'b1, 0);
    cycles(2);
    pop_chk(8'h61);
    send_frame(8'h64, 1'b1, 0);
    send_frame(8'h65, 1'b1, 0);
    cycles(2);
    chk("wrap_full", {31'd0, bus.full}, 32'd1);
    pop_chk(8'h62);
    pop_chk(8'h63);
    send_frame(8'h66, 1'b1, 0);
    cycles(2);
    pop_chk(8'h64);
    pop_chk(8'h65);
    pop_chk(8'h66);
    chk("wrap_empty", {31'd0, bus.empty}, 32'd1);

    // Full + overrun, then reset in the middle of a frame.
    send_frame(8'hC1, 1'b1, 0);
    send_frame(8'hC2, 1'b1, 0);
    send_frame(8'hC3, 1'b1, 0);
    send_frame(8'hC4, 1'b1, 0);
    send_frame(8'hC5, 1'b1, 0);
    cycles(2);
    chk("pre_rst_full", {31'd0, bus.full}, 32'd1);
    chk("pre_rst_ovr", {31'd0, bus.overrun}, 32'd1);
    rx = 1'b0;
    cycles(50);
    rst_n = 1'b0;
    rx    = 1'b1;
    #2;
    chk("mid_rst_empty",   {31'd0, bus.empty},   32'd1);
    chk("mid_rst_full",    {31'd0, bus.full},    32'd0);
    chk("mid_rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("mid_rst_data",    {24'd0, bus.data},    32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    send_frame(8'h5A, 1'b1, 0);
    cycles(2);
    pop_chk(8'h5A);
    chk("final_empty", {31'd0, bus.empty}, 32'd1);
    cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
